disk_dma_controller: RTL and testbench

Block-transfer engine that sits between the hard-disk model and the data memory and drives both ports as initiator. On a start request it copies a contiguous run of words either disk→memory (program/data load) or memory→disk (save), at one word per clock, absorbing the one-cycle registered-address read latency of both devices. The processor or boot logic starts it and then waits on `busy` and `done`.

---
 rtl/disk_pkg.sv | 17 +
 rtl/disk_dma_controller.sv | 158 +++++++++++++++
 tb/tb_disk_dma_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/disk_pkg.sv
// Shared definitions for the disk DMA engine and the disk/memory models:
// controller states, transfer direction codes and default geometry.
package disk_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 14;

  localparam logic DIR_HD_TO_MEM = 1'b0;
  localparam logic DIR_MEM_TO_HD = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COPY   = 2'b01,
    FINISH = 2'b10
  } disk_state_e;

endpackage

// File: rtl/disk_dma_controller.sv
// Block copy engine between the disk and data memory, one word per clock.
// Optional DISK_DMA_CHECKSUM_EN adds a running XOR of the written words.
module disk_dma_controller
  import disk_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  dir,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [DATA_WIDTH-1:0] hd_addr,
  output logic [DATA_WIDTH-1:0] hd_data,
  output logic                  hd_write,
  input  logic [DATA_WIDTH-1:0] hd_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done
`ifdef DISK_DMA_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [DATA_WIDTH-ADDR_WIDTH-1:0] ADDR_PAD = {(DATA_WIDTH-ADDR_WIDTH){1'b0}};

  disk_state_e           state_r;
  logic                  dir_r;
  logic [ADDR_WIDTH-1:0] hd_addr_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_left_r;
  logic                  hd_write_r;
  logic                  mem_write_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  // The done cycle is spent in IDLE, so a start held there waits one more edge.
  assign accept_s  = (state_r == IDLE) && start && !done_r;
  assign wr_data_s = (dir_r == DIR_MEM_TO_HD) ? mem_rdata : hd_rdata;

  assign hd_addr   = {ADDR_PAD, hd_addr_r};
  assign mem_addr  = {ADDR_PAD, mem_addr_r};
  assign hd_write  = hd_write_r;
  assign mem_write = mem_write_r;
  assign hd_data   = hd_write_r  ? wr_data_s : {DATA_WIDTH{1'b0}};
  assign mem_wdata = mem_write_r ? wr_data_s : {DATA_WIDTH{1'b0}};
  assign busy      = busy_r;
  assign done      = done_r;

  // Transfer sequencer: read pointer leads the write stage by one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      dir_r       <= 1'b0;
      hd_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
      rd_left_r   <= CNT_ZERO;
      hd_write_r  <= 1'b0;
      mem_write_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          hd_write_r  <= 1'b0;
          mem_write_r <= 1'b0;
          done_r      <= 1'b0;
          if (accept_s) begin
            dir_r    <= dir;
            wr_ptr_r <= dst_addr;
            busy_r   <= 1'b1;
            if (length == CNT_ZERO) begin
              rd_left_r <= CNT_ZERO;
              state_r   <= FINISH;
            end else begin
              rd_left_r <= length - CNT_ONE;
              state_r   <= COPY;
              if (dir == DIR_HD_TO_MEM) begin
                hd_addr_r <= src_addr;
              end else begin
                mem_addr_r <= src_addr;
              end
            end
          end
        end
        COPY: begin
          // Word read this cycle is written to the destination next cycle.
          if (dir_r == DIR_HD_TO_MEM) begin
            mem_addr_r  <= wr_ptr_r;
            mem_write_r <= 1'b1;
          end else begin
            hd_addr_r  <= wr_ptr_r;
            hd_write_r <= 1'b1;
          end
          wr_ptr_r <= wr_ptr_r + ADDR_ONE;
          if (rd_left_r == CNT_ZERO) begin
            state_r <= FINISH;
          end else begin
            rd_left_r <= rd_left_r - CNT_ONE;
            if (dir_r == DIR_HD_TO_MEM) begin
              hd_addr_r <= hd_addr_r + ADDR_ONE;
            end else begin
              mem_addr_r <= mem_addr_r + ADDR_ONE;
            end
          end
        end
        FINISH: begin
          hd_write_r  <= 1'b0;
          mem_write_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          hd_write_r  <= 1'b0;
          mem_write_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef DISK_DMA_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_r;

  assign checksum = checksum_r;

  // XOR of every word committed to the destination since the last accepted start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum_r <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      checksum_r <= {DATA_WIDTH{1'b0}};
    end else if (hd_write_r || mem_write_r) begin
      checksum_r <= checksum_r ^ wr_data_s;
    end else begin
      checksum_r <= checksum_r;
    end
  end
`endif

endmodule

// File: tb/tb_disk_dma_controller.sv
// Self-checking bench for disk_dma_controller with behavioural disk/memory
// models; checksum checks are compiled in when DISK_DMA_CHECKSUM_EN is defined.
module tb_disk_dma_controller;

  localparam int DW    = 32;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] hd_addr, hd_data, hd_rdata, mem_addr, mem_wdata, mem_rdata;
  logic          hd_write, mem_write, busy, done;
`ifdef DISK_DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] hd_arr  [0:DEPTH-1];
  logic [DW-1:0] mem_arr [0:DEPTH-1];
  logic [DW-1:0] exp_arr [0:DEPTH-1];
  logic [AW-1:0] hd_ra = '0;
  logic [AW-1:0] mem_ra = '0;

  int n_checks = 0;
  int n_pass = 0;

  disk_dma_controller dut (
    .clock(clock), .reset_n(reset_n), .start(start), .dir(dir),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .hd_addr(hd_addr), .hd_data(hd_data), .hd_write(hd_write), .hd_rdata(hd_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
`ifdef DISK_DMA_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  // Disk and memory: registered read address, synchronous write.
  always @(posedge clock) begin
    if (hd_write) hd_arr[hd_addr[AW-1:0]] <= hd_data;
    if (mem_write) mem_arr[mem_addr[AW-1:0]] <= mem_wdata;
    hd_ra  <= hd_addr[AW-1:0];
    mem_ra <= mem_addr[AW-1:0];
  end
  assign hd_rdata  = hd_arr[hd_ra];
  assign mem_rdata = mem_arr[mem_ra];

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %0h expected %0h", tag, got, want);
    else n_pass++;
  endtask

  // Expected image of the destination device after copying len words.
  task automatic build_expect(input bit d, input int src, input int dst, input int len,
                              output logic [DW-1:0] xsum);
    logic [DW-1:0] w;
    xsum = '0;
    for (int i = 0; i < DEPTH; i++) exp_arr[i] = d ? hd_arr[i] : mem_arr[i];
    for (int k = 0; k < len; k++) begin
      w = d ? mem_arr[(src + k) % DEPTH] : hd_arr[(src + k) % DEPTH];
      exp_arr[(dst + k) % DEPTH] = w;
      xsum ^= w;
    end
  endtask

  function automatic int dst_mismatches(input bit d);
    int m = 0;
    for (int i = 0; i < DEPTH; i++)
      if ((d ? hd_arr[i] : mem_arr[i]) !== exp_arr[i]) m++;
    return m;
  endfunction

  task automatic run_xfer(input bit d, input int src, input int dst, input int len,
                          input bit mid_start, input bit b2b, input bit chain);
    int lat = 0, busy_n = 0, dst_wr = 0, src_wr = 0;
    logic [DW-1:0] xsum;
    build_expect(d, src, dst, len, xsum);
    dir = d; src_addr = src[AW-1:0]; dst_addr = dst[AW-1:0]; length = len[AW:0]; start = 1'b1;
    if (b2b) begin
      @(posedge clock);
      @(negedge clock);
      check_value("b2b_not_yet_accepted", {63'd0, busy}, 64'd0);
    end
    @(posedge clock);
    #1;
    start = 1'b0;
    dir = 1'($urandom_range(0, 1));
    src_addr = AW'($urandom); dst_addr = AW'($urandom); length = (AW+1)'($urandom);
    for (int c = 1; c <= len + 8; c++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (d ? hd_write : mem_write) dst_wr++;
      if (d ? mem_write : hd_write) src_wr++;
      if (mid_start && c == 2) start = 1'b1;
      if (mid_start && c == 3) start = 1'b0;
      if (done) begin
        lat = c;
        check_value("busy_low_at_done", {63'd0, busy}, 64'd0);
        break;
      end
    end
    check_value("done_latency", lat, len + 2);
    check_value("busy_cycles", busy_n, len + 1);
    check_value("dst_writes", dst_wr, len);
    check_value("src_write_strobe", src_wr, 0);
    check_value("dst_contents", dst_mismatches(d), 0);
`ifdef DISK_DMA_CHECKSUM_EN
    check_value("checksum", checksum, xsum);
`endif
    if (!chain) begin
      @(negedge clock);
      check_value("done_once", {63'd0, done}, 64'd0);
      check_value("idle_after_done", {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    logic [DW-1:0] xs;
    int wr;
    int s, t;
    for (int i = 0; i < DEPTH; i++) begin
      hd_arr[i]  <= 32'(i) + 32'h100;
      mem_arr[i] <= $urandom;
    end
    repeat (3) @(negedge clock);
    check_value("rst_hd_addr", hd_addr, 0);
    check_value("rst_hd_data", hd_data, 0);
    check_value("rst_hd_write", {63'd0, hd_write}, 0);
    check_value("rst_mem_addr", mem_addr, 0);
    check_value("rst_mem_wdata", mem_wdata, 0);
    check_value("rst_mem_write", {63'd0, mem_write}, 0);
    check_value("rst_busy", {63'd0, busy}, 0);
    check_value("rst_done", {63'd0, done}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Disk to memory, fixed pattern.
    run_xfer(1'b0, 4, 'h20, 3, 1'b0, 1'b0, 1'b0);
    check_value("mem_20", mem_arr['h20], 64'h104);
    check_value("mem_21", mem_arr['h21], 64'h105);
    check_value("mem_22", mem_arr['h22], 64'h106);

    // Memory to disk with destination wrap.
    mem_arr[0] <= 32'hDEADBEEF;
    mem_arr[1] <= 32'h12345678;
    #1;
    run_xfer(1'b1, 0, 'h3FFF, 2, 1'b0, 1'b0, 1'b0);
    check_value("hd_3fff", hd_arr['h3FFF], 64'hDEADBEEF);
    check_value("hd_0", hd_arr[0], 64'h12345678);

    run_xfer(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1), 0,
             1'b0, 1'b0, 1'b0);
    run_xfer(1'b0, $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1), 6, 1'b1, 1'b0, 1'b0);

    // Reset after four of eight writes.
    s = 100; t = 200;
    build_expect(1'b0, s, t, 4, xs);
    dir = 1'b0; src_addr = AW'(s); dst_addr = AW'(t); length = 15'd8; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wr = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (mem_write) wr++;
      if (wr == 4) break;
    end
    check_value("writes_before_reset", wr, 4);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_value("mid_rst_mem_write", {63'd0, mem_write}, 0);
    check_value("mid_rst_hd_write", {63'd0, hd_write}, 0);
    check_value("mid_rst_busy", {63'd0, busy}, 0);
    check_value("mid_rst_done", {63'd0, done}, 0);
    check_value("mid_rst_addrs", {hd_addr, mem_addr}, 0);
    check_value("mid_rst_wdata", {hd_data, mem_wdata}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_value("reset_partial_contents", dst_mismatches(1'b0), 0);

    // Checksum pattern {1,2,4,8}, also the first transfer after reset.
    for (int i = 0; i < 4; i++) hd_arr['h50 + i] <= 32'd1 << i;
    #1;
    run_xfer(1'b0, 'h50, 'h300, 4, 1'b0, 1'b0, 1'b0);
`ifdef DISK_DMA_CHECKSUM_EN
    check_value("checksum_f", checksum, 64'hF);
`endif

    for (int r = 0; r < 6; r++)
      run_xfer(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
               $urandom_range(1, 40), 1'b0, 1'b0, 1'b0);
    run_xfer(1'b1, DEPTH - 2, DEPTH - 3, 5, 1'b0, 1'b0, 1'b0);

    // Start held into the done cycle is taken one edge later.
    run_xfer(1'b0, $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1), 5, 1'b0, 1'b0, 1'b1);
    run_xfer(1'b1, $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1), 7, 1'b0, 1'b1, 1'b0);

    run_xfer(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
             DEPTH, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
